// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM encoding and MUL cycle count for alu_sequencer (ALU_SEQUENCER_MUL_EN enables MUL)
package alu_seq_pkg;
  typedef enum logic [2:0] {
    OP_FWD = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLL = 3'd4,
    OP_SRL = 3'd5,
    OP_MUL = 3'd6,
    OP_RSV = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE, EXEC, FIN} state_e;
  localparam int MUL_CYCLES = 8;
  function automatic logic is_reserved(input op_e op);
`ifdef ALU_SEQUENCER_MUL_EN
    return op == OP_RSV;
`else
    return op == OP_RSV || op == OP_MUL;
`endif
  endfunction
endpackage

// File: rtl/alu_sequencer_zero_detect.sv
// zero_detect: flags an all-zero byte
module zero_detect (
  input  logic [7:0] value,
  output logic       zero
);
  assign zero = ~|value;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle 8-bit ALU with start/ready/done handshake (ALU_SEQUENCER_MUL_EN adds shift-add MUL)
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       zero,
  output logic       illegal
);
  state_e state, state_next;
  op_e op, opc;
  logic [7:0] a, b, sh, res_next;
  logic [3:0] cnt, cnt_init;
  logic ill_q, last, zero_next;
`ifdef ALU_SEQUENCER_MUL_EN
  logic [7:0] acc;
`endif
  assign opc = op_e'(opcode);
  assign ready = state == IDLE;
  assign busy = state == EXEC;
  assign done = state == FIN;
  assign illegal = done & ill_q;
  assign last = cnt <= 4'd1;
  assign sh = op == OP_SLL ? a << 1 : a >> 1;
  // State register; reset aborts any operation in flight
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  // Next state: shifts and MUL stay in EXEC until the cycle counter runs out
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? EXEC : IDLE;
      EXEC:    state_next = last ? FIN : EXEC;
      default: state_next = IDLE;
    endcase
  end
  // EXEC cycle count: shift amount (0 still takes one cycle), MUL_CYCLES for MUL, else one
  always_comb begin
    cnt_init = (opc == OP_SLL || opc == OP_SRL) ? {1'b0, data2[2:0]} : 4'd1;
`ifdef ALU_SEQUENCER_MUL_EN
    if (opc == OP_MUL) cnt_init = 4'(MUL_CYCLES);
`endif
  end
  // Result as it will look after the final EXEC cycle
  always_comb begin
    res_next = 8'h00;
    case (op)
      OP_FWD:  res_next = b;
      OP_ADD:  res_next = a + b;
      OP_AND:  res_next = a & b;
      OP_OR:   res_next = a | b;
      OP_SLL,
      OP_SRL:  res_next = cnt == 4'd0 ? a : sh;
`ifdef ALU_SEQUENCER_MUL_EN
      OP_MUL:  res_next = acc + (b[0] ? a : 8'h00);
`endif
      default: res_next = 8'h00;
    endcase
  end
  zero_detect u_zero_detect (.value(res_next), .zero(zero_next));
  // Operand capture on accept, iterative work in EXEC, result published only on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= OP_FWD;
      a <= 8'h00;
      b <= 8'h00;
      cnt <= 4'd0;
      ill_q <= 1'b0;
      result <= 8'h00;
      zero <= 1'b1;
`ifdef ALU_SEQUENCER_MUL_EN
      acc <= 8'h00;
`endif
    end else if (state == IDLE && start) begin
      op <= opc;
      a <= data1;
      b <= data2;
      cnt <= cnt_init;
      ill_q <= is_reserved(opc);
`ifdef ALU_SEQUENCER_MUL_EN
      acc <= 8'h00;
`endif
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      if (op == OP_SLL || op == OP_SRL) a <= sh;
`ifdef ALU_SEQUENCER_MUL_EN
      if (op == OP_MUL) begin
        acc <= acc + (b[0] ? a : 8'h00);
        a <= a << 1;
        b <= b >> 1;
      end
`endif
      if (last) begin
        result <= res_next;
        zero <= zero_next;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer (honours ALU_SEQUENCER_MUL_EN)
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;
  logic ready, busy, done, zero, illegal;
  logic [7:0] result;
  int checks = 0;
  int fails = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .data1(data1), .data2(data2), .ready(ready), .busy(busy),
    .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2,
                     output int lat, output int nbusy);
    @(negedge clk);
    opcode = op; data1 = d1; data2 = d2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; opcode = ~op; data1 = ~d1; data2 = ~d2;
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      nbusy += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [7:0] d1,
                          input logic [7:0] d2, input int exp_lat, input logic [7:0] exp_res,
                          input logic exp_ill);
    int lat, nb;
    run(op, d1, d2, lat, nb);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, int'(result), int'(exp_res));
    check({tag, "_zero"}, int'(zero), int'(exp_res == 8'h00));
    check({tag, "_ill"}, int'(illegal), int'(exp_ill));
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(done), 0);
    check({tag, "_ready_after"}, int'(ready), 1);
    check({tag, "_hold"}, int'(result), int'(exp_res));
  endtask

  initial begin
    int lat, nb, acc_n, done_n;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ill", int'(illegal), 0);
    check("rst_result", int'(result), 0);
    check("rst_zero", int'(zero), 1);
    reset = 1'b0;

    op_check("add_carry", 3'b001, 8'hF0, 8'h10, 2, 8'h00, 1'b0);
    op_check("fwd", 3'b000, 8'h11, 8'h5A, 2, 8'h5A, 1'b0);
    op_check("and", 3'b010, 8'hC3, 8'h5A, 2, 8'h42, 1'b0);
    op_check("or", 3'b011, 8'hC3, 8'h5A, 2, 8'hDB, 1'b0);
    op_check("add", 3'b001, 8'h37, 8'h25, 2, 8'h5C, 1'b0);

    run(3'b100, 8'h81, 8'h03, lat, nb);
    check("sll3_lat", lat, 4);
    check("sll3_busy", nb, 3);
    check("sll3_res", int'(result), 8'h08);
    check("sll3_zero", int'(zero), 0);
    op_check("sll0", 3'b100, 8'h81, 8'h00, 2, 8'h81, 1'b0);
    op_check("srl7", 3'b101, 8'h81, 8'hFF, 8, 8'h01, 1'b0);
    op_check("srl2", 3'b101, 8'hB4, 8'h02, 3, 8'h2D, 1'b0);
`ifdef ALU_SEQUENCER_MUL_EN
    op_check("mul", 3'b110, 8'h13, 8'h11, 9, 8'h43, 1'b0);
    op_check("mul_ff", 3'b110, 8'hFF, 8'hFF, 9, 8'h01, 1'b0);
`else
    op_check("mul_off", 3'b110, 8'h13, 8'h11, 2, 8'h00, 1'b1);
`endif
    op_check("rsv", 3'b111, 8'hFF, 8'hFF, 2, 8'h00, 1'b1);

    // START held high across MUL operations: one DONE per accepted START
    @(negedge clk);
    opcode = 3'b110; data1 = 8'h13; data2 = 8'h11; start = 1'b1;
    acc_n = 0;
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      acc_n += int'(ready);
      done_n += int'(done);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      done_n += int'(done);
      @(negedge clk);
    end
`ifdef ALU_SEQUENCER_MUL_EN
    check("flood_accepts", acc_n, 2);
`else
    check("flood_accepts", acc_n, 7);
`endif
    check("flood_dones", done_n, acc_n);

    // Abort a long operation with reset at its fourth EXEC cycle
    op_check("preload", 3'b000, 8'h00, 8'h77, 2, 8'h77, 1'b0);
    @(negedge clk);
`ifdef ALU_SEQUENCER_MUL_EN
    opcode = 3'b110; data1 = 8'h13; data2 = 8'h11;
`else
    opcode = 3'b100; data1 = 8'h81; data2 = 8'h07;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy", int'(busy), 1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_ready", int'(ready), 1);
    check("abort_result", int'(result), 0);
    check("abort_zero", int'(zero), 1);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      done_n += int'(done) + int'(busy);
      @(negedge clk);
    end
    check("abort_no_done", done_n, 0);
    op_check("after_abort", 3'b001, 8'h03, 8'h04, 2, 8'h07, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
